// File: rtl/m216a_pkg.sv
// Shared constants, shelf record and fit predicate for the rectangle-placement engine.
package m216a_pkg;

    localparam int GRID_W      = 128;
    localparam int GRID_H      = 128;
    localparam int MAX_SHELVES = 16;
    localparam int SLOT        = 4;
    localparam int LATENCY     = 8;
    localparam int SHELF_IDX_W = 4;

    // Slot phases: the source changes inputs on PH_ISSUE, we sample on PH_CAPTURE.
    localparam logic [1:0] PH_ISSUE   = 2'd0;
    localparam logic [1:0] PH_HOLD    = 2'd1;
    localparam logic [1:0] PH_CAPTURE = 2'd2;
    localparam logic [1:0] PH_SEARCH  = 2'd3;

    typedef struct packed {
        logic [6:0] base_y;
        logic [4:0] height;
        logic [7:0] next_x;
        logic       valid;
    } shelf_t;

    function automatic logic shelf_fits(input shelf_t s, input logic [4:0] h, input logic [4:0] w);
        logic [8:0] end_x;
        end_x = {1'b0, s.next_x} + {4'b0000, w};
        return s.valid && (s.height >= h) && (end_x <= 9'(GRID_W));
    endfunction

endpackage

// File: rtl/m216a_shelf_fit_finder.sv
// Parallel fit test of every shelf against (h, w); the lowest-numbered fitting shelf wins.
module shelf_fit_finder
    import m216a_pkg::*;
(
    input  shelf_t [MAX_SHELVES-1:0] shelves_i,
    input  logic [4:0]               h_i,
    input  logic [4:0]               w_i,
    output logic                     hit_o,
    output logic [SHELF_IDX_W-1:0]   idx_o
);

    logic [MAX_SHELVES-1:0] fit_vec;

    always_comb begin
        fit_vec = '0;
        for (int i = 0; i < MAX_SHELVES; i++) begin
            fit_vec[i] = shelf_fits(shelves_i[i], h_i, w_i);
        end
    end

    // Walk from the top down so the last write is the oldest fitting shelf.
    always_comb begin
        hit_o = |fit_vec;
        idx_o = '0;
        for (int i = MAX_SHELVES - 1; i >= 0; i--) begin
            if (fit_vec[i]) begin
                idx_o = SHELF_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/m216a_top_module.sv
// First-fit shelf packer: one request per 4-cycle slot, result released 8 cycles after issue.
module m216a_top_module
    import m216a_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] height_i,
    input  logic [4:0] width_i,
    output logic [7:0] index_x_o,
    output logic [7:0] index_y_o,
    output logic [3:0] strike_o
);

    logic [1:0]                   phase_q, phase_d;
    logic [4:0]                   cap_h_q, cap_h_d;
    logic [4:0]                   cap_w_q, cap_w_d;
    logic                         fit_hit_q, fit_hit_d;
    logic [SHELF_IDX_W-1:0]       fit_idx_q, fit_idx_d;
    shelf_t [MAX_SHELVES-1:0]     shelves_q, shelves_d;
    logic [4:0]                   shelf_cnt_q, shelf_cnt_d;
    logic [7:0]                   top_y_q, top_y_d;

    // One-slot result delay stage between the state update and the outputs.
    logic                         st_valid_q, st_valid_d;
    logic                         st_strike_q, st_strike_d;
    logic [7:0]                   st_x_q, st_x_d;
    logic [7:0]                   st_y_q, st_y_d;

    logic [7:0]                   idx_x_q, idx_x_d;
    logic [7:0]                   idx_y_q, idx_y_d;
    logic [3:0]                   strike_q, strike_d;

    logic                         finder_hit;
    logic [SHELF_IDX_W-1:0]       finder_idx;
    logic                         req_valid;
    logic [8:0]                   new_end_y;
    logic                         room_for_shelf;
    logic [SHELF_IDX_W-1:0]       new_idx;

    shelf_fit_finder u_finder (
        .shelves_i (shelves_q),
        .h_i       (cap_h_q),
        .w_i       (cap_w_q),
        .hit_o     (finder_hit),
        .idx_o     (finder_idx)
    );

    always_comb begin
        req_valid      = (cap_h_q != 5'd0) && (cap_w_q != 5'd0);
        new_end_y      = {1'b0, top_y_q} + {4'b0000, cap_h_q};
        room_for_shelf = (new_end_y <= 9'(GRID_H)) && (shelf_cnt_q < 5'(MAX_SHELVES));
        new_idx        = shelf_cnt_q[SHELF_IDX_W-1:0];
    end

    always_comb begin
        phase_d     = phase_q + 2'd1;
        cap_h_d     = cap_h_q;
        cap_w_d     = cap_w_q;
        fit_hit_d   = fit_hit_q;
        fit_idx_d   = fit_idx_q;
        shelves_d   = shelves_q;
        shelf_cnt_d = shelf_cnt_q;
        top_y_d     = top_y_q;
        st_valid_d  = st_valid_q;
        st_strike_d = st_strike_q;
        st_x_d      = st_x_q;
        st_y_d      = st_y_q;
        idx_x_d     = idx_x_q;
        idx_y_d     = idx_y_q;
        strike_d    = strike_q;

        case (phase_q)
            PH_CAPTURE: begin
                cap_h_d = height_i;
                cap_w_d = width_i;
            end
            PH_SEARCH: begin
                fit_hit_d = finder_hit;
                fit_idx_d = finder_idx;
            end
            PH_ISSUE: begin
                // Release the previous slot's result before overwriting the delay stage.
                if (st_valid_q) begin
                    idx_x_d = st_x_q;
                    idx_y_d = st_y_q;
                    if (st_strike_q && (strike_q != 4'hF)) begin
                        strike_d = strike_q + 4'd1;
                    end
                end

                st_valid_d  = req_valid;
                st_strike_d = 1'b0;
                st_x_d      = 8'd0;
                st_y_d      = 8'd0;
                if (req_valid) begin
                    if (fit_hit_q) begin
                        st_x_d = shelves_q[fit_idx_q].next_x;
                        st_y_d = {1'b0, shelves_q[fit_idx_q].base_y};
                        shelves_d[fit_idx_q].next_x = shelves_q[fit_idx_q].next_x + {3'b000, cap_w_q};
                    end else if (room_for_shelf) begin
                        shelves_d[new_idx].base_y = top_y_q[6:0];
                        shelves_d[new_idx].height = cap_h_q;
                        shelves_d[new_idx].next_x = {3'b000, cap_w_q};
                        shelves_d[new_idx].valid  = 1'b1;
                        st_y_d      = top_y_q;
                        top_y_d     = new_end_y[7:0];
                        shelf_cnt_d = shelf_cnt_q + 5'd1;
                    end else begin
                        st_strike_d = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q     <= PH_ISSUE;
            cap_h_q     <= '0;
            cap_w_q     <= '0;
            fit_hit_q   <= 1'b0;
            fit_idx_q   <= '0;
            shelves_q   <= '0;
            shelf_cnt_q <= '0;
            top_y_q     <= '0;
            st_valid_q  <= 1'b0;
            st_strike_q <= 1'b0;
            st_x_q      <= '0;
            st_y_q      <= '0;
            idx_x_q     <= '0;
            idx_y_q     <= '0;
            strike_q    <= '0;
        end else begin
            phase_q     <= phase_d;
            cap_h_q     <= cap_h_d;
            cap_w_q     <= cap_w_d;
            fit_hit_q   <= fit_hit_d;
            fit_idx_q   <= fit_idx_d;
            shelves_q   <= shelves_d;
            shelf_cnt_q <= shelf_cnt_d;
            top_y_q     <= top_y_d;
            st_valid_q  <= st_valid_d;
            st_strike_q <= st_strike_d;
            st_x_q      <= st_x_d;
            st_y_q      <= st_y_d;
            idx_x_q     <= idx_x_d;
            idx_y_q     <= idx_y_d;
            strike_q    <= strike_d;
        end
    end

    assign index_x_o = idx_x_q;
    assign index_y_o = idx_y_q;
    assign strike_o  = strike_q;

endmodule

// File: tb/tb_m216a_top_module.sv
// Directed bench for the shelf packer: each slot's hand-computed result is checked on every
// cycle of the slot two later, where it must be held.
module tb_m216a_top_module;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] h   = '0;
    logic [4:0] w   = '0;
    logic [7:0] x_o;
    logic [7:0] y_o;
    logic [3:0] s_o;

    int          errors = 0;
    int          checks = 0;
    logic [19:0] exp_q[$];
    logic [19:0] shown = '0;

    m216a_top_module dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .height_i  (h),
        .width_i   (w),
        .index_x_o (x_o),
        .index_y_o (y_o),
        .strike_o  (s_o)
    );

    always #5 clk = ~clk;

    task automatic check_out(input string tag);
        logic [19:0] got;
        got = {x_o, y_o, s_o};
        checks++;
        assert (got === shown) else begin
            errors++;
            $error("FAIL %s: got x=%0d y=%0d strike=%0d, expected x=%0d y=%0d strike=%0d",
                   tag, got[19:12], got[11:4], got[3:0], shown[19:12], shown[11:4], shown[3:0]);
        end
    endtask

    // Drive one slot; outputs seen during this slot belong to the request two slots back.
    task automatic run_slot(input logic [4:0] hh, input logic [4:0] ww,
                            input logic [7:0] ex, input logic [7:0] ey,
                            input logic [3:0] es, input string tag);
        exp_q.push_back({ex, ey, es});
        if (exp_q.size() == 3) shown = exp_q.pop_front();
        h = hh;
        w = ww;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_out(tag);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        h   = '0;
        w   = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        shown = '0;
        check_out("reset");
        exp_q.delete();
        rst = 1'b0;
    endtask

    initial begin
        do_reset(10);

        run_slot(5'd4, 5'd10, 8'd0,  8'd0, 4'd0, "first_a");
        run_slot(5'd4, 5'd20, 8'd10, 8'd0, 4'd0, "first_b");
        run_slot(5'd6, 5'd5,  8'd0,  8'd4, 4'd0, "new_shelf");
        run_slot(5'd3, 5'd7,  8'd30, 8'd0, 4'd0, "fit_low_shelf");
        run_slot(5'd0, 5'd0,  8'd30, 8'd0, 4'd0, "idle_hold");
        run_slot(5'd2, 5'd3,  8'd37, 8'd0, 4'd0, "after_idle");
        run_slot(5'd0, 5'd0,  8'd37, 8'd0, 4'd0, "flush_a");
        run_slot(5'd0, 5'd0,  8'd37, 8'd0, 4'd0, "flush_b");

        // Sixteen rows of four 31-wide rectangles fill all 128 rows exactly.
        do_reset(3);
        for (int s = 0; s < 16; s++) begin
            for (int j = 0; j < 4; j++) begin
                run_slot(5'd8, 5'd31, 8'(31 * j), 8'(8 * s), 4'd0,
                         $sformatf("fill_r%0d_c%0d", s, j));
            end
        end
        run_slot(5'd4, 5'd4, 8'd124, 8'd0, 4'd0, "exact_edge_fit");
        run_slot(5'd1, 5'd1, 8'd124, 8'd8, 4'd0, "second_shelf_fit");
        for (int i = 1; i <= 16; i++) begin
            run_slot(5'd8, 5'd31, 8'd0, 8'd0, 4'(i > 15 ? 15 : i), $sformatf("strike_%0d", i));
        end
        run_slot(5'd0, 5'd0, 8'd0, 8'd0, 4'd15, "idle_strike_hold");
        run_slot(5'd4, 5'd5, 8'd0, 8'd0, 4'd15, "strike_saturated");
        run_slot(5'd0, 5'd0, 8'd0, 8'd0, 4'd15, "flush_c");
        run_slot(5'd0, 5'd0, 8'd0, 8'd0, 4'd15, "flush_d");

        // Reset lands on the phase-2 edge of a slot carrying (5,5).
        h = 5'd5;
        w = 5'd5;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        shown = '0;
        check_out("mid_reset_a");
        @(posedge clk);
        #1;
        check_out("mid_reset_b");
        exp_q.delete();
        h   = '0;
        w   = '0;
        rst = 1'b0;

        run_slot(5'd3, 5'd3, 8'd0, 8'd0, 4'd0, "post_reset_a");
        run_slot(5'd2, 5'd2, 8'd3, 8'd0, 4'd0, "post_reset_b");
        run_slot(5'd0, 5'd0, 8'd3, 8'd0, 4'd0, "flush_e");
        run_slot(5'd0, 5'd0, 8'd3, 8'd0, 4'd0, "flush_f");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
